piso_tx: RTL

Parallel-in, serial-out transmitter: the sending end of the right-shift serial link whose receiver is clocked by a serial clock and samples one data bit per rising edge. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and emits each word LSB-first on PT_SOUT with a generated serial clock PT_SCLK. After WIDTH PT_SCLK rising edges the receiver's parallel register holds the transmitted word exactly.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_tx_bit_timer.sv | 32 +++
 rtl/piso_tx.sv | 97 +++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx serial transmitter.
package piso_pkg;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_CLKS_PER_BIT = 4;

   // Counter width for a range 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Per-bit phase counter: marks the last cycle of each bit and the high half of the serial clock.
module bit_timer
   import piso_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic bit_end,
   output logic sclk_hi
);

   localparam int PW = cnt_w(CLKS_PER_BIT);
   localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(CLKS_PER_BIT / 2);

   logic [PW-1:0] phase;

   always_ff @(posedge clk) begin
      if (rst || !run)
         phase <= '0;
      else if (bit_end)
         phase <= '0;
      else
         phase <= phase + 1'b1;
   end

   assign bit_end = run && (phase == PH_LAST);
   assign sclk_hi = run && (phase >= PH_HALF);

endmodule

// File: rtl/piso_tx.sv
// LSB-first serial transmitter with a one-word holding buffer and a generated serial clock.
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic             PT_CLK,
   input  logic             PT_RST,
   input  logic [WIDTH-1:0] PT_DATA,
   input  logic             PT_VALID,
   output logic             PT_READY,
   output logic             PT_SOUT,
   output logic             PT_SCLK,
   output logic             PT_BUSY,
   output logic             PT_DONE
);

   localparam int BW = cnt_w(WIDTH);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bitcnt;
   logic             done_q;
   logic             bit_end, sclk_hi;
   logic             accept, load_idle, last_bit, reload;

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk     (PT_CLK),
      .rst     (PT_RST),
      .run     (state == SHIFT),
      .bit_end (bit_end),
      .sclk_hi (sclk_hi)
   );

   assign accept    = PT_VALID && !hold_full;
   assign load_idle = (state == IDLE) && hold_full;
   assign last_bit  = bit_end && (bitcnt == BIT_LAST);
   assign reload    = load_idle || (last_bit && hold_full);

   always_ff @(posedge PT_CLK) begin
      if (PT_RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hold_full) state_nxt = SHIFT;
         SHIFT:   if (last_bit && !hold_full) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Buffer payload carries no reset; hold_full alone says whether it is meaningful.
   always_ff @(posedge PT_CLK) begin
      if (accept)
         hold <= PT_DATA;
   end

   always_ff @(posedge PT_CLK) begin
      if (PT_RST) begin
         hold_full <= 1'b0;
         shreg     <= '0;
         bitcnt    <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= last_bit;
         if (accept)
            hold_full <= 1'b1;
         if (reload) begin
            shreg     <= hold;
            hold_full <= 1'b0;
            bitcnt    <= '0;
         end else if (last_bit) begin
            bitcnt <= '0;
         end else if (bit_end) begin
            shreg  <= {1'b0, shreg[WIDTH-1:1]};
            bitcnt <= bitcnt + 1'b1;
         end
      end
   end

   always_comb begin
      PT_READY = !hold_full;
      PT_BUSY  = (state == SHIFT);
      PT_SOUT  = (state == SHIFT) && shreg[0];
      PT_SCLK  = sclk_hi;
      PT_DONE  = done_q;
   end

endmodule
